// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM states, SPI mode
// encoding and a helper for sizing the slave-select index.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_e;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = 2'b00;
  localparam spi_mode_t MODE1 = 2'b01;
  localparam spi_mode_t MODE2 = 2'b10;
  localparam spi_mode_t MODE3 = 2'b11;

  // Index width for a select of n entries, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/spi_master_param_if.sv
// Bundle of the control handshake and the SPI pin group.
// master: the SPI master block; slave: whatever drives/observes it.
interface spi_master_param_if #(
  parameter int DATA_W   = 8,
  parameter int NUM_SS   = 1,
  parameter int SS_IDX_W = 1
);
  logic              start;
  logic [DATA_W-1:0] tx_data;
  logic [SS_IDX_W-1:0] ss_sel;
  logic              cpol;
  logic              cpha;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_SS-1:0] ss_n;

  modport master (
    input  start, tx_data, ss_sel, cpol, cpha, miso,
    output busy, done, rx_data, sclk, mosi, ss_n
  );

  modport slave (
    output start, tx_data, ss_sel, cpol, cpha, miso,
    input  busy, done, rx_data, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_clk_gen.sv
// Half-period tick generator: while en is high, tick pulses once every
// CLK_DIV cycles. restart reloads the count so the first tick after a
// restart lands exactly CLK_DIV cycles later.
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic restart,
  output logic tick
);
  localparam int CW = $clog2(CLK_DIV) + 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && !restart && (cnt_q == '0);

  // Down-counter next state: reload on restart or on every tick.
  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = RELOAD;
    end else if (en) begin
      if (cnt_q == '0) cnt_d = RELOAD;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= RELOAD;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master. One frame per accepted start:
// SETUP (select asserted, first bit on mosi for cpha=0), XFER (2*DATA_W
// sclk edges), HOLD (select kept), then a done pulse with the new word.
module spi_master_param
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int NUM_SS    = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter int SS_IDX_W  = idx_w(NUM_SS)
) (
  input logic clk,
  input logic rst_n,
  spi_master_param_if.master bus
);
  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  spi_mode_t         mode_q, mode_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              done_q, done_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic [NUM_SS-1:0] sel_dec;
  logic              tick;

  // Bit currently at the head of the outgoing word.
  function automatic logic head_bit(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? w[DATA_W-1] : w[0];
  endfunction

  // Drop the head bit, moving the next one into its place.
  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
    return MSB_FIRST ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
  endfunction

  // Append a received bit so the first one ends up at the head position.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w,
                                                 input logic b);
    return MSB_FIRST ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
  endfunction

  // Active-low decode of the requested slave; out-of-range leaves all high.
  for (genvar gi = 0; gi < NUM_SS; gi++) begin : g_sel
    assign sel_dec[gi] = (bus.ss_sel != SS_IDX_W'(gi));
  end

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state_q != IDLE),
    .restart (state_q == IDLE),
    .tick    (tick)
  );

  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;
  assign bus.sclk    = sclk_q;
  assign bus.mosi    = mosi_q;
  assign bus.ss_n    = ss_n_q;

  // Next-state and datapath decisions for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    bit_cnt_d = bit_cnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    ss_n_d    = ss_n_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        sclk_d = bus.cpol;
        mosi_d = 1'b0;
        if (bus.start) begin
          state_d   = SETUP;
          mode_d    = '{cpol: bus.cpol, cpha: bus.cpha};
          ss_n_d    = sel_dec;
          bit_cnt_d = '0;
          rx_sh_d   = '0;
          if (bus.cpha) begin
            tx_sh_d = bus.tx_data;
          end else begin
            mosi_d  = head_bit(bus.tx_data);
            tx_sh_d = shift_out(bus.tx_data);
          end
        end
      end
      SETUP: begin
        if (tick) state_d = XFER;
      end
      XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (sclk_q == mode_q.cpol) begin
            // Leading edge.
            if (mode_q.cpha) begin
              mosi_d  = head_bit(tx_sh_q);
              tx_sh_d = shift_out(tx_sh_q);
            end else begin
              rx_sh_d = shift_in(rx_sh_q, bus.miso);
            end
          end else begin
            // Trailing edge closes one bit.
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (mode_q.cpha) rx_sh_d = shift_in(rx_sh_q, bus.miso);
            if (bit_cnt_q == LAST_BIT) begin
              state_d = HOLD;
            end else if (!mode_q.cpha) begin
              mosi_d  = head_bit(tx_sh_q);
              tx_sh_d = shift_out(tx_sh_q);
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
          ss_n_d    = '1;
          mosi_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
      ss_n_q    <= '1;
    end else begin
      mode_q    <= mode_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      bit_cnt_q <= bit_cnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
      ss_n_q    <= ss_n_d;
    end
  end
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: two instances (8-bit MSB-first /2 divider with
// four selects, and 12-bit LSB-first /1 divider), each with a behavioural
// SPI slave and a done-triggered monitor that checks against queued
// expectations pushed when a frame is issued.
module tb_spi_master_param;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  spi_master_param_if #(.DATA_W(8),  .NUM_SS(4), .SS_IDX_W(3)) ifa ();
  spi_master_param_if #(.DATA_W(12), .NUM_SS(1), .SS_IDX_W(1)) ifb ();

  spi_master_param #(.DATA_W(8), .CLK_DIV(2), .NUM_SS(4), .MSB_FIRST(1'b1), .SS_IDX_W(3)) u_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.master));
  spi_master_param #(.DATA_W(12), .CLK_DIV(1), .NUM_SS(1), .MSB_FIRST(1'b0), .SS_IDX_W(1)) u_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.master));

  typedef struct {
    string       name;
    logic [11:0] rx;
    logic [11:0] tx;
    int          edges;
    int          lat;
    logic [3:0]  ssn;
    logic        cpol;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Slave-side state (written by the bench, read by the slave processes).
  logic [7:0]  sa_word;
  logic        sa_cpol, sa_cpha;
  logic [11:0] sb_word;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Slave + monitor for instance A (MSB first, 8 bits).
  initial begin
    logic [7:0] sh, cap;
    logic prev, bprev, ssbad;
    int edges, acc;
    exp_t e;
    ifa.miso = 1'b0;
    prev = 1'b0; bprev = 1'b0; ssbad = 1'b0; edges = 0; acc = 0; sh = '0; cap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bprev = 1'b0;
        prev  = ifa.sclk;
      end else begin
        if (ifa.done) begin
          if (qa.size() == 0) begin
            tests++; fails++;
            $display("FAIL A_unexpected_done: done=1, required no pending frame");
          end else begin
            e = qa.pop_front();
            chk($sformatf("%s_rx", e.name), ifa.rx_data, e.rx);
            chk($sformatf("%s_mosi_word", e.name), cap, e.tx);
            chk($sformatf("%s_edges", e.name), edges, e.edges);
            chk($sformatf("%s_latency", e.name), cyc - acc, e.lat);
            chk($sformatf("%s_ss_n_in_frame_bad", e.name), ssbad, 0);
            chk($sformatf("%s_ss_n_at_done", e.name), ifa.ss_n, 4'hF);
            chk($sformatf("%s_sclk_idle", e.name), ifa.sclk, e.cpol);
            $display("[TB] A %s: rx=%h mosi_word=%h edges=%0d latency=%0d", e.name, ifa.rx_data, cap, edges, cyc - acc);
          end
        end
        if (ifa.busy && !bprev) begin
          acc = cyc - 1; edges = 0; cap = '0; ssbad = 1'b0; sh = sa_word;
          if (!sa_cpha) ifa.miso = sh[7];
        end else if (ifa.busy && (ifa.sclk !== prev)) begin
          edges++;
          if (prev == sa_cpol) begin
            if (!sa_cpha) cap = {cap[6:0], ifa.mosi};
            else begin ifa.miso = sh[7]; sh = sh << 1; end
          end else begin
            if (sa_cpha) cap = {cap[6:0], ifa.mosi};
            else begin sh = sh << 1; ifa.miso = sh[7]; end
          end
        end
        if (ifa.busy && qa.size() > 0 && ifa.ss_n !== qa[0].ssn) ssbad = 1'b1;
        prev  = ifa.sclk;
        bprev = ifa.busy;
      end
    end
  end

  // Slave + monitor for instance B (LSB first, 12 bits, mode 0).
  initial begin
    logic [11:0] sh, cap;
    logic prev, bprev, ssbad;
    int edges, acc;
    exp_t e;
    ifb.miso = 1'b0;
    prev = 1'b0; bprev = 1'b0; ssbad = 1'b0; edges = 0; acc = 0; sh = '0; cap = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bprev = 1'b0;
        prev  = ifb.sclk;
      end else begin
        if (ifb.done) begin
          if (qb.size() == 0) begin
            tests++; fails++;
            $display("FAIL B_unexpected_done: done=1, required no pending frame");
          end else begin
            e = qb.pop_front();
            chk($sformatf("%s_rx", e.name), ifb.rx_data, e.rx);
            chk($sformatf("%s_mosi_word", e.name), cap, e.tx);
            chk($sformatf("%s_edges", e.name), edges, e.edges);
            chk($sformatf("%s_latency", e.name), cyc - acc, e.lat);
            chk($sformatf("%s_ss_n_in_frame_bad", e.name), ssbad, 0);
            chk($sformatf("%s_ss_n_at_done", e.name), ifb.ss_n, 1);
            chk($sformatf("%s_sclk_idle", e.name), ifb.sclk, e.cpol);
            $display("[TB] B %s: rx=%h mosi_word=%h edges=%0d latency=%0d", e.name, ifb.rx_data, cap, edges, cyc - acc);
          end
        end
        if (ifb.busy && !bprev) begin
          acc = cyc - 1; edges = 0; cap = '0; ssbad = 1'b0; sh = sb_word;
          ifb.miso = sh[0];
        end else if (ifb.busy && (ifb.sclk !== prev)) begin
          edges++;
          if (prev == 1'b0) cap = {ifb.mosi, cap[11:1]};
          else begin sh = sh >> 1; ifb.miso = sh[0]; end
        end
        if (ifb.busy && qb.size() > 0 && {3'b000, ifb.ss_n} !== qb[0].ssn) ssbad = 1'b1;
        prev  = ifb.sclk;
        bprev = ifb.busy;
      end
    end
  end

  task automatic reset_checks(input string tag);
    chk({tag, "_A_busy"}, ifa.busy, 0);
    chk({tag, "_A_done"}, ifa.done, 0);
    chk({tag, "_A_rx_data"}, ifa.rx_data, 0);
    chk({tag, "_A_sclk"}, ifa.sclk, 0);
    chk({tag, "_A_mosi"}, ifa.mosi, 0);
    chk({tag, "_A_ss_n"}, ifa.ss_n, 4'hF);
    chk({tag, "_B_busy"}, ifb.busy, 0);
    chk({tag, "_B_ss_n"}, ifb.ss_n, 1);
    $display("[TB] %s: reset state sampled", tag);
  endtask

  task automatic wait_done(input bit is_b, input int maxc, input string name);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (is_b ? ifb.done : ifa.done) break;
      n++;
      if (n > maxc) begin
        tests++; fails++;
        $display("FAIL %s_timeout: no done within %0d cycles, required a done pulse", name, maxc);
        break;
      end
    end
    #1;
  endtask

  // Drive one accepted start on A and queue its expectation (cpol already settled).
  task automatic issue_a(input string name, input logic [7:0] tx, input logic [7:0] word,
                         input spi_mode_t m, input logic [2:0] sel, input logic [3:0] ssn);
    exp_t e;
    ifa.tx_data = tx; ifa.ss_sel = sel; ifa.cpol = m.cpol; ifa.cpha = m.cpha;
    sa_word = word; sa_cpol = m.cpol; sa_cpha = m.cpha;
    e.name = name; e.rx = {4'h0, word}; e.tx = {4'h0, tx}; e.edges = 16; e.lat = 37;
    e.ssn = ssn; e.cpol = m.cpol;
    qa.push_back(e);
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
  endtask

  // Full frame on A with the mode inputs and tx word disturbed mid-frame.
  task automatic frame_a(input string name, input logic [7:0] tx, input logic [7:0] word,
                         input spi_mode_t m, input logic [2:0] sel, input logic [3:0] ssn);
    @(posedge clk); #1;
    ifa.cpol = m.cpol; ifa.cpha = m.cpha;
    repeat (2) @(posedge clk); #1;
    issue_a(name, tx, word, m, sel, ssn);
    ifa.tx_data = ~tx; ifa.ss_sel = 3'd3; ifa.cpha = ~m.cpha;
    wait_done(1'b0, 100, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t eb;
    ifa.start = 0; ifa.tx_data = '0; ifa.ss_sel = '0; ifa.cpol = 0; ifa.cpha = 0;
    ifb.start = 0; ifb.tx_data = '0; ifb.ss_sel = '0; ifb.cpol = 0; ifb.cpha = 0;
    sa_word = '0; sa_cpol = 0; sa_cpha = 0; sb_word = '0;
    repeat (3) @(posedge clk); #1;
    reset_checks("por");
    @(negedge clk) rst_n = 1'b1;

    // Mode 0 baseline, 8 bits, /2: done at cycle 37, 16 edges.
    frame_a("t1_m0", 8'hB7, 8'h5A, MODE0, 3'd0, 4'b1110);
    // Remaining modes.
    frame_a("t2_m1", 8'hC3, 8'h3C, MODE1, 3'd0, 4'b1110);
    frame_a("t2_m2", 8'hC3, 8'h3C, MODE2, 3'd0, 4'b1110);
    frame_a("t2_m3", 8'hC3, 8'h3C, MODE3, 3'd0, 4'b1110);
    // Slave selection, including an index beyond NUM_SS.
    frame_a("t3_ss2", 8'h12, 8'hE4, MODE0, 3'd2, 4'b1011);
    frame_a("t3_ss5", 8'h6D, 8'h0F, MODE0, 3'd5, 4'b1111);

    // Starts while busy are dropped; start in the done cycle is taken.
    @(posedge clk); #1;
    ifa.cpol = 0; ifa.cpha = 0;
    repeat (2) @(posedge clk); #1;
    issue_a("t4_f1", 8'h81, 8'h7E, MODE0, 3'd0, 4'b1110);
    repeat (4) @(posedge clk); #1;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    repeat (14) @(posedge clk); #1;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    wait_done(1'b0, 100, "t4_f1");
    issue_a("t4_f2", 8'h3C, 8'hA5, MODE0, 3'd1, 4'b1101);
    wait_done(1'b0, 100, "t4_f2");

    // Asynchronous reset in the middle of a frame.
    @(posedge clk); #1;
    ifa.cpol = 0; ifa.cpha = 0;
    repeat (2) @(posedge clk); #1;
    issue_a("t5_killed", 8'hFF, 8'h00, MODE0, 3'd0, 4'b1110);
    repeat (14) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    qa.delete();
    #1;
    reset_checks("t5_midframe");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    frame_a("t5_after", 8'h69, 8'h96, MODE0, 3'd1, 4'b1101);

    // 12-bit LSB-first, /1 divider: 24 edges, done at cycle 27.
    @(posedge clk); #1;
    ifb.tx_data = 12'hA5C; ifb.ss_sel = 1'b0; ifb.cpol = 0; ifb.cpha = 0;
    sb_word = 12'h3A6;
    eb.name = "t6_lsb"; eb.rx = 12'h3A6; eb.tx = 12'hA5C; eb.edges = 24; eb.lat = 27;
    eb.ssn = 4'b0000; eb.cpol = 1'b0;
    qb.push_back(eb);
    ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    wait_done(1'b1, 100, "t6_lsb");

    repeat (5) @(posedge clk); #1;
    chk("A_queue_drained", qa.size(), 0);
    chk("B_queue_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
